// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared command, channel and state encodings for the LED key controller
package led_pkg;

    localparam logic [1:0] CMD_RST  = 2'd0;
    localparam logic [1:0] CMD_NEXT = 2'd1;
    localparam logic [1:0] CMD_UP   = 2'd2;
    localparam logic [1:0] CMD_DOWN = 2'd3;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/led_key_arb.sv
// rtl/led_key_arb.sv - fixed-priority key pulse arbiter (lowest bit wins)
module led_key_arb (
    input  logic [3:0] req_i,
    output logic       valid_o,
    output logic [1:0] cmd_o
);
    import led_pkg::*;

    always_comb begin
        valid_o = |req_i;
        cmd_o   = CMD_RST;
        if (req_i[0]) begin
            cmd_o = CMD_RST;
        end else if (req_i[1]) begin
            cmd_o = CMD_NEXT;
        end else if (req_i[2]) begin
            cmd_o = CMD_UP;
        end else if (req_i[3]) begin
            cmd_o = CMD_DOWN;
        end
    end

endmodule

// File: rtl/led_key_ctrl.sv
// rtl/led_key_ctrl.sv - key command FSM driving three saturating RGB duty registers
module led_key_ctrl #(
    parameter int DW       = 8,
    parameter int STEP     = 8,
    parameter int DEF_DUTY = 0,
    parameter int REP_DLY  = 12,
    parameter int REP_RATE = 4
) (
    input  logic          CLK,
    input  logic          CLR_N,
    input  logic          CE_IN,
    input  logic [3:0]    KEY_PULSE,
    input  logic [3:0]    KEY_LEVEL,
    output logic [1:0]    SEL,
    output logic [DW-1:0] DUTY_R,
    output logic [DW-1:0] DUTY_G,
    output logic [DW-1:0] DUTY_B,
    output logic          UPD,
    output logic          BUSY
);
    import led_pkg::*;

    localparam int            RMAX     = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
    localparam int            CW       = $clog2(RMAX + 1);
    localparam logic [DW:0]   STEP_X   = (DW+1)'(STEP);
    localparam logic [DW-1:0] DUTY_MAX = '1;
    localparam logic [DW-1:0] DEF_D    = DW'(DEF_DUTY);
    localparam logic [CW-1:0] DLY_C    = CW'(REP_DLY);
    localparam logic [CW-1:0] RATE_C   = CW'(REP_RATE);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    state_e        state_q, state_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [1:0]    sel_q, sel_d;
    logic          rep_q, rep_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic          upd_q, upd_d;
    logic          busy_q, busy_d;

    logic          arb_valid;
    logic [1:0]    arb_cmd;
    logic [DW-1:0] cur, nxt;
    logic [DW:0]   sum;

    led_key_arb u_arb (
        .req_i   (KEY_PULSE),
        .valid_o (arb_valid),
        .cmd_o   (arb_cmd)
    );

    // Saturating step on the selected channel, computed one bit wider to catch overflow
    always_comb begin
        case (sel_q)
            CH_G:    cur = g_q;
            CH_B:    cur = b_q;
            default: cur = r_q;
        endcase
        sum = {1'b0, cur} + STEP_X;
        if (cmd_q == CMD_UP) begin
            nxt = sum[DW] ? DUTY_MAX : sum[DW-1:0];
        end else begin
            nxt = ({1'b0, cur} < STEP_X) ? '0 : DW'({1'b0, cur} - STEP_X);
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        sel_d   = sel_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        upd_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    cmd_d   = arb_cmd;
                    rep_d   = 1'b0;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                upd_d = 1'b1;
                case (cmd_q)
                    CMD_RST: begin
                        sel_d = CH_R;
                        r_d   = DEF_D;
                        g_d   = DEF_D;
                        b_d   = DEF_D;
                    end
                    CMD_NEXT: sel_d = (sel_q == CH_B) ? CH_R : sel_q + 2'd1;
                    default: begin
                        case (sel_q)
                            CH_G:    g_d = nxt;
                            CH_B:    b_d = nxt;
                            default: r_d = nxt;
                        endcase
                    end
                endcase
                if (cmd_q == CMD_UP || cmd_q == CMD_DOWN) begin
                    state_d = ST_HOLD;
                    cnt_d   = rep_q ? RATE_C : DLY_C;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
                if (KEY_PULSE[CMD_RST]) begin
                    state_d = ST_APPLY;
                    cmd_d   = CMD_RST;
                    rep_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (KEY_PULSE[CMD_RST]) begin
                    state_d = ST_APPLY;
                    cmd_d   = CMD_RST;
                    rep_d   = 1'b0;
                    cnt_d   = '0;
                end else if (!KEY_LEVEL[cmd_q]) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (CE_IN) begin
                    cnt_d = cnt_q - ONE_C;
                    if (cnt_q == ONE_C) begin
                        state_d = ST_APPLY;
                        rep_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_RST;
            sel_q   <= CH_R;
            rep_q   <= 1'b0;
            cnt_q   <= '0;
            r_q     <= DEF_D;
            g_q     <= DEF_D;
            b_q     <= DEF_D;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            sel_q   <= sel_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
        end
    end

    assign SEL    = sel_q;
    assign DUTY_R = r_q;
    assign DUTY_G = g_q;
    assign DUTY_B = b_q;
    assign UPD    = upd_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_led_key_ctrl.sv
// tb/tb_led_key_ctrl.sv - scoreboard bench for led_key_ctrl with directed key sequences
module tb_led_key_ctrl;

    logic       CLK;
    logic       CLR_N;
    logic       CE_IN;
    logic [3:0] KEY_PULSE;
    logic [3:0] KEY_LEVEL;
    logic [1:0] SEL;
    logic [7:0] DUTY_R, DUTY_G, DUTY_B;
    logic       UPD;
    logic       BUSY;

    led_key_ctrl dut (
        .CLK       (CLK),
        .CLR_N     (CLR_N),
        .CE_IN     (CE_IN),
        .KEY_PULSE (KEY_PULSE),
        .KEY_LEVEL (KEY_LEVEL),
        .SEL       (SEL),
        .DUTY_R    (DUTY_R),
        .DUTY_G    (DUTY_G),
        .DUTY_B    (DUTY_B),
        .UPD       (UPD),
        .BUSY      (BUSY)
    );

    typedef struct {
        logic [1:0] sel;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];
    int   upd_cyc[$];
    int   upd_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int r, input int g, input int b);
        exp_t e;
        e.sel = 2'(s);
        e.r   = 8'(r);
        e.g   = 8'(g);
        e.b   = 8'(b);
        sb.push_back(e);
    endtask

    // Monitor: every UPD strobe must match the oldest expected state
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (UPD === 1'b1) begin
                upd_cnt++;
                upd_cyc.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_upd: got sel=%0d r=%0d g=%0d b=%0d expected no UPD",
                             SEL, DUTY_R, DUTY_G, DUTY_B);
                end else begin
                    e = sb.pop_front();
                    if (SEL !== e.sel || DUTY_R !== e.r || DUTY_G !== e.g || DUTY_B !== e.b) begin
                        errors++;
                        $display("FAIL upd_%0d: got sel=%0d r=%0d g=%0d b=%0d expected sel=%0d r=%0d g=%0d b=%0d",
                                 upd_cnt, SEL, DUTY_R, DUTY_G, DUTY_B, e.sel, e.r, e.g, e.b);
                    end
                end
            end
        end
    end

    task automatic pulse(input logic [3:0] m, output int k);
        @(posedge CLK);
        #1;
        KEY_PULSE = m;
        k = cyc;
        @(posedge CLK);
        #1;
        KEY_PULSE = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic at_cycle(input int t);
        while (cyc < t) begin
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        #1;
    endtask

    task automatic hold_wait(input int target, output bit ok);
        for (int i = 0; i < 600; i++) begin
            @(posedge CLK);
            #1;
            if (upd_cnt >= target) break;
        end
        ok = (upd_cnt >= target);
        chk("hold_upd_count", upd_cnt, target);
    endtask

    function automatic int last_upd();
        return (upd_cyc.size() == 0) ? -1 : upd_cyc[upd_cyc.size()-1];
    endfunction

    initial begin
        int k;
        int n0;
        int i0;
        bit ok;
        CLR_N     = 1'b0;
        CE_IN     = 1'b1;
        KEY_PULSE = 4'b0000;
        KEY_LEVEL = 4'b0000;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_sel", SEL, 0);
        chk("rst_r", DUTY_R, 0);
        chk("rst_g", DUTY_G, 0);
        chk("rst_b", DUTY_B, 0);
        chk("rst_upd", UPD, 0);
        chk("rst_busy", BUSY, 0);
        CLR_N = 1'b1;
        idle(5);

        // Single UP with key already released: 2-cycle latency, one UPD, back to idle
        n0 = upd_cnt;
        pulse(4'b0100, k);
        push(0, 8, 0, 0);
        at_cycle(k + 3);
        chk("up_latency", last_upd(), k + 2);
        chk("up_busy_cleared", BUSY, 0);
        at_cycle(k + 4);
        chk("up_single_upd", upd_cnt - n0, 1);

        for (int i = 1; i <= 3; i++) begin
            pulse(4'b0010, k);
            push(i % 3, 8, 0, 0);
            idle(4);
        end
        pulse(4'b0001, k);
        push(0, 0, 0, 0);
        idle(4);

        // Held UP on R: first repeat after 12 ticks, then every 4
        KEY_LEVEL = 4'b0100;
        i0 = upd_cyc.size();
        n0 = upd_cnt;
        pulse(4'b0100, k);
        for (int i = 1; i <= 7; i++) push(0, 8 * i, 0, 0);
        hold_wait(n0 + 7, ok);
        KEY_LEVEL = 4'b0000;
        if (ok) begin
            chk("rep_first_gap", upd_cyc[i0+1] - upd_cyc[i0], 13);
            chk("rep_second_gap", upd_cyc[i0+2] - upd_cyc[i0+1], 5);
            chk("rep_last_gap", upd_cyc[i0+6] - upd_cyc[i0+5], 5);
        end
        idle(20);
        chk("release_idle", BUSY, 0);

        pulse(4'b0001, k);
        push(0, 0, 0, 0);
        idle(4);
        pulse(4'b0010, k);
        push(1, 0, 0, 0);
        idle(4);

        // Held UP on G to saturation: 8..248, then 255 twice
        KEY_LEVEL = 4'b0100;
        n0 = upd_cnt;
        pulse(4'b0100, k);
        for (int i = 1; i <= 31; i++) push(1, 0, 8 * i, 0);
        push(1, 0, 255, 0);
        push(1, 0, 255, 0);
        hold_wait(n0 + 33, ok);
        KEY_LEVEL = 4'b0000;
        idle(10);

        // Held DOWN on G from 255: 247..7, then clamps at 0 (7 - 8 must not wrap)
        KEY_LEVEL = 4'b1000;
        n0 = upd_cnt;
        pulse(4'b1000, k);
        for (int i = 1; i <= 31; i++) push(1, 0, 255 - 8 * i, 0);
        push(1, 0, 0, 0);
        push(1, 0, 0, 0);
        hold_wait(n0 + 33, ok);
        pulse(4'b0001, k);
        push(0, 0, 0, 0);
        at_cycle(k + 3);
        chk("preempt_latency", last_upd(), k + 2);
        chk("preempt_idle", BUSY, 0);
        KEY_LEVEL = 4'b0000;
        idle(4);

        pulse(4'b1100, k);
        push(0, 8, 0, 0);
        idle(6);
        pulse(4'b0011, k);
        push(0, 0, 0, 0);
        idle(4);

        pulse(4'b0010, k);
        push(1, 0, 0, 0);
        idle(4);
        pulse(4'b0010, k);
        push(2, 0, 0, 0);
        idle(4);
        pulse(4'b1000, k);
        push(2, 0, 0, 0);
        idle(6);
        pulse(4'b0100, k);
        push(2, 0, 0, 8);
        idle(6);
        pulse(4'b0010, k);
        push(0, 0, 0, 8);
        idle(6);

        // Asynchronous reset while APPLY of an UP is in flight
        pulse(4'b0100, k);
        chk("apply_busy", BUSY, 1);
        #2;
        CLR_N = 1'b0;
        #1;
        chk("async_b", DUTY_B, 0);
        chk("async_busy", BUSY, 0);
        chk("async_sel", SEL, 0);
        chk("async_upd", UPD, 0);
        @(posedge CLK);
        #1;
        chk("async_r_kept", DUTY_R, 0);
        CLR_N = 1'b1;
        idle(8);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
